// File: rtl/dumper_pkg.sv
// Shared types and default sizing for the DRAM dump initiator.
package dumper_pkg;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 10;
  localparam int READ_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT,
    FIN
  } state_e;

endpackage

// File: rtl/dump_csum.sv
// Modulo-2^DATA_W running sum of the words handed to the host link.
module dump_csum #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + add_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/dram_dumper.sv
// Reads a block of consecutive DRAM words and streams them out on valid/ready.
// Define DRAM_DUMPER_CHECKSUM_EN to add a running checksum of streamed words.
module dram_dumper
  import dumper_pkg::*;
#(
  parameter int ADDR_W   = dumper_pkg::ADDR_W,
  parameter int DATA_W   = dumper_pkg::DATA_W,
  parameter int CNT_W    = dumper_pkg::CNT_W,
  parameter int READ_LAT = dumper_pkg::READ_LAT
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              proc_running,
  output logic              start_4,
  output logic              read_en_ext,
  output logic [ADDR_W-1:0] addr_ext,
  input  logic [DATA_W-1:0] dram_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int LAT_W = $clog2(READ_LAT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    data_d  = data_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          if (proc_running) begin
            err_d = 1'b1;
          end else if (word_count == '0) begin
            state_d = FIN;
          end else begin
            addr_d  = base_addr;
            rem_d   = word_count;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        lat_d   = LAT_W'(READ_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          data_d  = dram_data;
          state_d = OUT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? FIN : ISSUE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The core taking the DRAM back wins over anything the dump was doing.
    if (state_q != IDLE && proc_running) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Read controls stay up through WAIT so the top-level address register holds.
  assign start_4     = (state_q == ISSUE) || (state_q == WAIT);
  assign read_en_ext = start_4;
  assign addr_ext    = addr_q;
  assign out_data    = data_q;
  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign err         = err_q;

`ifdef DRAM_DUMPER_CHECKSUM_EN
  logic csum_clear;
  logic csum_add;

  assign csum_clear = (state_q == IDLE) && dump_req && !proc_running;
  assign csum_add   = out_valid && out_ready && !proc_running;

  dump_csum #(
    .DATA_W(DATA_W)
  ) u_csum (
    .clock   (clock),
    .rst_n   (rst_n),
    .clear   (csum_clear),
    .add_en  (csum_add),
    .add_data(data_q),
    .sum     (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_dram_dumper.sv
// Scoreboard bench for dram_dumper: directed dumps against a two-stage DRAM model.
module tb_dram_dumper;
  import dumper_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_req = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  word_count = '0;
  logic        proc_running = 1'b0;
  logic        start_4, read_en_ext;
  logic [8:0]  addr_ext;
  logic [15:0] dram_data = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, err;
  logic [15:0] checksum;

  dram_dumper dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .dump_req    (dump_req),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .proc_running(proc_running),
    .start_4     (start_4),
    .read_en_ext (read_en_ext),
    .addr_ext    (addr_ext),
    .dram_data   (dram_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .checksum    (checksum)
  );

  always #5 clock = ~clock;

  // Top-level address register followed by the synchronous DRAM read.
  logic [15:0] mem [0:511];
  logic [8:0]  addr_reg = '0;
  always @(posedge clock) begin
    if (start_4) addr_reg <= addr_ext;
    if (read_en_ext) dram_data <= mem[addr_reg];
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

`ifdef DRAM_DUMPER_CHECKSUM_EN
  function automatic logic [15:0] expCsum(input logic [15:0] v);
    return v;
  endfunction
`else
  function automatic logic [15:0] expCsum(input logic [15:0] v);
    return (v == v) ? 16'h0000 : 16'hFFFF;
  endfunction
`endif

  logic [15:0] exp_data_q[$];
  logic [8:0]  exp_addr_q[$];

  int cyc = 0;
  int done_cnt, err_cnt, issue_cnt, hs_cnt;
  int first_issue, first_valid, last_hs_cyc, done_cyc, req_cyc;
  bit busy_seen;
  bit prev_start = 1'b0;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  // Monitor: pops expectations whenever the DUT issues a read or hands over a word.
  always @(negedge clock) begin
    cyc++;
    if (!rst_n) begin
      prev_start = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (dump_req) req_cyc = cyc;
      if (start_4 && !prev_start) begin
        issue_cnt++;
        if (first_issue < 0) first_issue = cyc;
        if (exp_addr_q.size() == 0) timeoutFail("unexpected_issue");
        else checkOutput("issue_addr", 32'(addr_ext), 32'(exp_addr_q.pop_front()));
      end
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_data_q.size() == 0) timeoutFail("unexpected_word");
        else checkOutput("word", 32'(out_data), 32'(exp_data_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (busy) busy_seen = 1'b1;
      prev_start = start_4;
      prev_stall = out_valid && !out_ready && !proc_running;
      prev_data  = out_data;
    end
  end

  task automatic clearStats();
    done_cnt = 0; err_cnt = 0; issue_cnt = 0; hs_cnt = 0;
    first_issue = -1; first_valid = -1; last_hs_cyc = -1; done_cyc = -1; req_cyc = -1;
    busy_seen = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic applyStimulus(input logic [8:0] base, input logic [9:0] cnt, input bit expect_words);
    logic [8:0] a;
    @(posedge clock); #1;
    base_addr  = base;
    word_count = cnt;
    dump_req   = 1'b1;
    if (expect_words) begin
      for (int i = 0; i < int'(cnt); i++) begin
        a = base + 9'(i);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(mem[a]);
      end
    end
    @(posedge clock); #1;
    dump_req   = 1'b0;
    base_addr  = 9'h1FF;
    word_count = 10'h3FF;
  endtask

  task automatic waitEnd(input int budget);
    int n = 0;
    while (done_cnt + err_cnt == 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    if (done_cnt + err_cnt == 0) timeoutFail("wait_end");
    repeat (2) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start_4"}, 32'(start_4), 32'd0);
    checkOutput({tag, "_read_en"}, 32'(read_en_ext), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i) ^ 16'hC000;
    mem[10] = 16'h1111; mem[11] = 16'h2222; mem[12] = 16'h3333; mem[13] = 16'h4444;
    mem[510] = 16'h5A10; mem[511] = 16'h5A11; mem[0] = 16'h5A00;
    clearStats();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("reset");
    checkOutput("reset_addr_ext", 32'(addr_ext), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_checksum", 32'(checksum), 32'd0);
    rst_n = 1'b1;

    // Basic four-word dump
    $display("[TB] basic dump");
    clearStats();
    applyStimulus(9'd10, 10'd4, 1'b1);
    waitEnd(200);
    checkOutput("basic_words", 32'(hs_cnt), 32'd4);
    checkOutput("basic_issues", 32'(issue_cnt), 32'd4);
    checkOutput("basic_done", 32'(done_cnt), 32'd1);
    checkOutput("basic_err", 32'(err_cnt), 32'd0);
    // Capture lands READ_LAT cycles after issue; the word shows one cycle later.
    checkOutput("issue_to_valid", 32'(first_valid - first_issue), 32'(READ_LAT + 1));
    checkOutput("done_after_hs", 32'(done_cyc - last_hs_cyc), 32'd1);
    checkOutput("basic_busy_after", 32'(busy), 32'd0);
    checkOutput("basic_left", 32'(exp_data_q.size()), 32'd0);
    checkOutput("basic_checksum", 32'(checksum), 32'(expCsum(16'hAAAA)));

    // Back-pressure on word 2
    $display("[TB] stalled dump");
    clearStats();
    applyStimulus(9'd10, 10'd4, 1'b1);
    n = 0;
    while (hs_cnt < 1 && n < 100) begin @(posedge clock); #1; n++; end
    if (hs_cnt < 1) timeoutFail("stall_sync");
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
    if (!out_valid) timeoutFail("stall_valid_wait");
    checkOutput("stall_word2", 32'(out_data), 32'h2222);
    repeat (5) begin @(posedge clock); #1; end
    out_ready = 1'b1;
    waitEnd(200);
    checkOutput("stall_words", 32'(hs_cnt), 32'd4);
    checkOutput("stall_issues", 32'(issue_cnt), 32'd4);
    checkOutput("stall_done", 32'(done_cnt), 32'd1);

    // Address wrap
    $display("[TB] wrap dump");
    clearStats();
    applyStimulus(9'd510, 10'd3, 1'b1);
    waitEnd(200);
    checkOutput("wrap_words", 32'(hs_cnt), 32'd3);
    checkOutput("wrap_done", 32'(done_cnt), 32'd1);
    checkOutput("wrap_checksum", 32'(checksum), 32'(expCsum(16'h0E21)));

    // Zero-length dump
    $display("[TB] zero-length dump");
    clearStats();
    applyStimulus(9'd10, 10'd0, 1'b1);
    waitEnd(50);
    checkOutput("zero_done", 32'(done_cnt), 32'd1);
    checkOutput("zero_done_lat", 32'(done_cyc - req_cyc), 32'd1);
    checkOutput("zero_issues", 32'(issue_cnt), 32'd0);
    checkOutput("zero_no_valid", 32'(first_valid < 0), 32'd1);
    checkOutput("zero_checksum", 32'(checksum), 32'd0);

    // Refused while the core runs
    $display("[TB] refused dump");
    clearStats();
    proc_running = 1'b1;
    applyStimulus(9'd10, 10'd4, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    checkOutput("refuse_err", 32'(err_cnt), 32'd1);
    checkOutput("refuse_busy", 32'(busy_seen), 32'd0);
    checkOutput("refuse_done", 32'(done_cnt), 32'd0);
    checkOutput("refuse_issues", 32'(issue_cnt), 32'd0);
    proc_running = 1'b0;

    // Abort in the WAIT of word 2
    $display("[TB] aborted dump");
    clearStats();
    applyStimulus(9'd10, 10'd4, 1'b1);
    n = 0;
    while (issue_cnt < 2 && n < 100) begin @(posedge clock); #1; n++; end
    if (issue_cnt < 2) timeoutFail("abort_sync");
    proc_running = 1'b1;
    @(posedge clock); #1;
    checkAllZero("abort");
    checkOutput("abort_err_now", 32'(err), 32'd1);
    repeat (3) begin @(posedge clock); #1; end
    checkOutput("abort_err", 32'(err_cnt), 32'd1);
    checkOutput("abort_done", 32'(done_cnt), 32'd0);
    checkOutput("abort_words", 32'(hs_cnt), 32'd1);
    checkOutput("abort_checksum", 32'(checksum), 32'(expCsum(16'h1111)));
    proc_running = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();

    // Asynchronous reset mid-dump
    $display("[TB] reset mid-dump");
    clearStats();
    applyStimulus(9'd10, 10'd4, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
    if (!out_valid) timeoutFail("reset_sync");
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    checkOutput("async_rst_out_data", 32'(out_data), 32'd0);
    checkOutput("async_rst_addr", 32'(addr_ext), 32'd0);
    checkOutput("async_rst_checksum", 32'(checksum), 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    exp_data_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
